// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
//   Level controller for the block-stacker game. Walks through NUM_LEVELS
//   levels under go / next_signal / fail control. It derives each level's
//   frame period and row width arithmetically. It also generates the frame
//   tick that moves the active row.
//
// Ports
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   go           in   start / resume / restart request (level-sampled)
//   next_signal  in   row placed successfully, advance one level
//   fail         in   row missed, game over
//   speed_count  out  frame period (clocks) for the current level
//   num_blocks   out  row width (blocks) for the current level
//   curr_level   out  current level, 1-based
//   playing      out  high while in PLAY
//   won          out  high while in WIN
//   lost         out  high while in LOSE
//   tick         out  one-cycle frame pulse, only while playing
// -----------------------------------------------------------------------------
module level_sequencer #(
    parameter int unsigned NUM_LEVELS   = 15,
    parameter int unsigned LVL_W        = 4,
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned BASE_COUNT   = 50000000,
    parameter int unsigned STEP_COUNT   = 3000000,
    parameter int unsigned MIN_COUNT    = 2500000,
    parameter int unsigned MAX_BLOCKS   = 4,
    parameter int unsigned BLK_W        = 3,
    parameter int unsigned SHRINK_EVERY = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic             next_signal,
    input  logic             fail,
    output logic [CNT_W-1:0] speed_count,
    output logic [BLK_W-1:0] num_blocks,
    output logic [LVL_W-1:0] curr_level,
    output logic             playing,
    output logic             won,
    output logic             lost,
    output logic             tick
);

    // Wide enough for (level-1)*STEP_COUNT without wrapping.
    localparam int unsigned WIDE = CNT_W + LVL_W;

    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(NUM_LEVELS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_t;

    // Frame period for a level, clamped at MIN_COUNT. The reduction is compared
    // against the headroom (BASE-MIN) before subtracting, so it never underflows.
    function automatic logic [CNT_W-1:0] speed_of(input logic [LVL_W-1:0] lvl);
        logic [WIDE-1:0] reduction;
        reduction = (WIDE'(lvl) - WIDE'(1)) * WIDE'(STEP_COUNT);
        if (reduction >= WIDE'(BASE_COUNT - MIN_COUNT)) begin
            return CNT_W'(MIN_COUNT);
        end
        return CNT_W'(WIDE'(BASE_COUNT) - reduction);
    endfunction

    // Row width: lose one block every SHRINK_EVERY levels, never below one.
    function automatic logic [BLK_W-1:0] blocks_of(input logic [LVL_W-1:0] lvl);
        logic [31:0] shrink;
        shrink = (32'(lvl) - 32'd1) / 32'(SHRINK_EVERY);
        if (shrink + 32'd1 >= 32'(MAX_BLOCKS)) begin
            return BLK_ONE;
        end
        return BLK_W'(32'(MAX_BLOCKS) - shrink);
    endfunction

    state_t           state_reg, state_next;
    logic [LVL_W-1:0] level_reg, level_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] speed_reg, speed_next;
    logic [BLK_W-1:0] blocks_reg, blocks_next;
    logic             tick_reg, tick_next;
    logic             playing_reg, won_reg, lost_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_WAIT;
            level_reg   <= LVL_ONE;
            count_reg   <= '0;
            speed_reg   <= speed_of(LVL_ONE);
            blocks_reg  <= blocks_of(LVL_ONE);
            tick_reg    <= 1'b0;
            playing_reg <= 1'b0;
            won_reg     <= 1'b0;
            lost_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            level_reg   <= level_next;
            count_reg   <= count_next;
            speed_reg   <= speed_next;
            blocks_reg  <= blocks_next;
            tick_reg    <= tick_next;
            playing_reg <= (state_next == ST_PLAY);
            won_reg     <= (state_next == ST_WIN);
            lost_reg    <= (state_next == ST_LOSE);
        end
    end

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        // The counter is zero in every state but a continuing PLAY, so it is
        // already clear on each entry to PLAY.
        count_next = '0;

        case (state_reg)
            ST_WAIT: begin
                if (go) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (fail) begin
                    state_next = ST_LOSE;
                end else if (next_signal) begin
                    if (level_reg < LVL_LAST) begin
                        level_next = level_reg + LVL_ONE;
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_WIN;
                    end
                end else if (count_reg == speed_reg - CNT_ONE) begin
                    count_next = '0;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (go) begin
                    state_next = ST_WAIT;
                    level_next = LVL_ONE;
                end
            end
            default: begin
                state_next = ST_WAIT;
            end
        endcase

        speed_next  = speed_of(level_next);
        blocks_next = blocks_of(level_next);
        // The registered tick is high exactly in the cycle where the counter
        // sits at speed_count-1. Qualifying it on the next state keeps it low
        // outside PLAY.
        tick_next   = (state_next == ST_PLAY) && (count_next == speed_reg - CNT_ONE);
    end

    assign speed_count = speed_reg;
    assign num_blocks  = blocks_reg;
    assign curr_level  = level_reg;
    assign playing     = playing_reg;
    assign won         = won_reg;
    assign lost        = lost_reg;
    assign tick        = tick_reg;

endmodule

// File: tb/tb_level_sequencer.sv
module tb_level_sequencer;

    localparam int NL    = 5;
    localparam int BASE  = 10;
    localparam int STEP  = 2;
    localparam int MINC  = 4;
    localparam int MAXB  = 3;
    localparam int SHR   = 2;
    localparam int CW    = 8;
    localparam int LW    = 4;
    localparam int BW    = 3;

    logic          clk;
    logic          resetn;
    logic          go;
    logic          next_signal;
    logic          fail;
    logic [CW-1:0] speed_count;
    logic [BW-1:0] num_blocks;
    logic [LW-1:0] curr_level;
    logic          playing;
    logic          won;
    logic          lost;
    logic          tick;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=wait 1=play 2=win 3=lose; phase counts PLAY
    // cycles since entry (1 in the first one).
    int m_mode;
    int m_level;
    int m_phase;

    level_sequencer #(
        .NUM_LEVELS(NL), .LVL_W(LW), .CNT_W(CW), .BASE_COUNT(BASE),
        .STEP_COUNT(STEP), .MIN_COUNT(MINC), .MAX_BLOCKS(MAXB),
        .BLK_W(BW), .SHRINK_EVERY(SHR)
    ) dut (
        .clk(clk), .resetn(resetn), .go(go), .next_signal(next_signal),
        .fail(fail), .speed_count(speed_count), .num_blocks(num_blocks),
        .curr_level(curr_level), .playing(playing), .won(won), .lost(lost),
        .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_speed(input int lvl);
        int s;
        s = BASE - (lvl - 1) * STEP;
        return (s < MINC) ? MINC : s;
    endfunction

    function automatic int exp_blocks(input int lvl);
        int b;
        b = MAXB - (lvl - 1) / SHR;
        return (b < 1) ? 1 : b;
    endfunction

    function automatic logic exp_tick();
        return (m_mode == 1) && (m_phase % exp_speed(m_level) == 0);
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_level = 1;
        m_phase = 0;
    endtask

    task automatic model_update(input logic g, input logic n, input logic f);
        case (m_mode)
            0: if (g) begin m_mode = 1; m_phase = 1; end
            1: begin
                if (f) m_mode = 3;
                else if (n) begin
                    if (m_level < NL) begin m_level++; m_mode = 0; end
                    else m_mode = 2;
                end else m_phase++;
            end
            default: if (g) begin m_mode = 0; m_level = 1; end
        endcase
    endtask

    // Drive one cycle of inputs; outputs are valid at the following negedge.
    task automatic step(input logic g, input logic n, input logic f);
        go = g; next_signal = n; fail = f;
        @(posedge clk);
        if (!resetn) model_reset();
        else model_update(g, n, f);
        @(negedge clk);
    endtask

    task automatic do_reset();
        go = 1'b0; next_signal = 1'b0; fail = 1'b0;
        resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (curr_level !== 4'd1) begin bad++; $display("FAIL reset_level: got %0d want 1", curr_level); end
        total++; if (speed_count !== 8'd10) begin bad++; $display("FAIL reset_speed: got %0d want 10", speed_count); end
        total++; if (num_blocks !== 3'd3) begin bad++; $display("FAIL reset_blocks: got %0d want 3", num_blocks); end
        total++; if ({playing, won, lost, tick} !== 4'b0000) begin bad++; $display("FAIL reset_status: got %b want 0000", {playing, won, lost, tick}); end
        $display("test_reset done level=%0d speed=%0d", curr_level, speed_count);
    endtask

    task automatic test_first_ticks();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        total++; if (playing !== 1'b1) begin bad++; $display("FAIL go_playing: got %b want 1", playing); end
        for (int k = 2; k <= 31; k++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if (tick !== ((k % 10) == 0)) begin
                bad++; $display("FAIL first_ticks cycle %0d: got %b want %b", k, tick, (k % 10) == 0);
            end
        end
        $display("test_first_ticks done");
    endtask

    task automatic test_levels();
        int spd [5];
        int blk [5];
        spd = '{10, 8, 6, 4, 4};
        blk = '{3, 3, 2, 2, 1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            total++; if (curr_level !== 4'(i + 1)) begin bad++; $display("FAIL level_num %0d: got %0d want %0d", i + 1, curr_level, i + 1); end
            total++; if (speed_count !== 8'(spd[i])) begin bad++; $display("FAIL level_speed %0d: got %0d want %0d", i + 1, speed_count, spd[i]); end
            total++; if (num_blocks !== 3'(blk[i])) begin bad++; $display("FAIL level_blocks %0d: got %0d want %0d", i + 1, num_blocks, blk[i]); end
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0);
            $display("level %0d passed through speed=%0d blocks=%0d", i + 1, spd[i], blk[i]);
        end
        total++; if (won !== 1'b1 || playing !== 1'b0) begin bad++; $display("FAIL win_state: got won=%b playing=%b want won=1 playing=0", won, playing); end
        total++; if (curr_level !== 4'd5) begin bad++; $display("FAIL win_level: got %0d want 5", curr_level); end
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 1'b0);
            total++; if (tick !== 1'b0 || won !== 1'b1) begin bad++; $display("FAIL win_hold cycle %0d: got tick=%b won=%b want tick=0 won=1", k, tick, won); end
        end
    endtask

    task automatic test_fail_priority();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        total++; if (lost !== 1'b1 || playing !== 1'b0 || won !== 1'b0) begin bad++; $display("FAIL fail_prio_state: got lost=%b playing=%b won=%b want 1 0 0", lost, playing, won); end
        total++; if (curr_level !== 4'd2) begin bad++; $display("FAIL fail_prio_level: got %0d want 2", curr_level); end
        step(1'b1, 1'b0, 1'b0);
        total++; if (curr_level !== 4'd1 || speed_count !== 8'd10) begin bad++; $display("FAIL restart: got level=%0d speed=%0d want 1 10", curr_level, speed_count); end
        total++; if ({playing, won, lost} !== 3'b000) begin bad++; $display("FAIL restart_state: got %b want 000", {playing, won, lost}); end
        $display("test_fail_priority done");
    endtask

    task automatic test_ignored_inputs();
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        total++; if (curr_level !== 4'd1 || {playing, won, lost} !== 3'b000) begin bad++; $display("FAIL wait_ignore: got level=%0d status=%b want 1 000", curr_level, {playing, won, lost}); end
        // go held through PLAY must not restart the tick counter
        step(1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 12; k++) begin
            step(1'b1, 1'b0, 1'b0);
            total++; if (tick !== (k == 10) || playing !== 1'b1) begin bad++; $display("FAIL go_in_play cycle %0d: got tick=%b playing=%b want tick=%b playing=1", k, tick, playing, k == 10); end
        end
        $display("test_ignored_inputs done");
    endtask

    task automatic test_next_midperiod();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        // Counter at 5; next_signal held for four cycles across the transition.
        repeat (4) step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b0, 1'b0);
            total++; if (tick !== 1'b0 || playing !== 1'b0 || curr_level !== 4'd2) begin bad++; $display("FAIL after_next cycle %0d: got tick=%b playing=%b level=%0d want 0 0 2", k, tick, playing, curr_level); end
        end
        step(1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            step(1'b0, 1'b0, 1'b0);
            total++; if (tick !== (k == 8)) begin bad++; $display("FAIL level2_tick cycle %0d: got %b want %b", k, tick, k == 8); end
        end
        $display("test_next_midperiod done");
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        total++; if (curr_level !== 4'd3 || playing !== 1'b1) begin bad++; $display("FAIL pre_reset: got level=%0d playing=%b want 3 1", curr_level, playing); end
        #2 resetn = 1'b0;
        #1;
        total++; if (curr_level !== 4'd1 || speed_count !== 8'd10 || num_blocks !== 3'd3) begin bad++; $display("FAIL async_values: got level=%0d speed=%0d blocks=%0d want 1 10 3", curr_level, speed_count, num_blocks); end
        total++; if ({playing, won, lost, tick} !== 4'b0000) begin bad++; $display("FAIL async_status: got %b want 0000", {playing, won, lost, tick}); end
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b0, 1'b0);
            total++; if (tick !== 1'b0 || playing !== 1'b0) begin bad++; $display("FAIL post_reset cycle %0d: got tick=%b playing=%b want 0 0", k, tick, playing); end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        logic g, n, f;
        do_reset();
        for (int t = 0; t < 800; t++) begin
            g = ($urandom_range(0, 3) == 0);
            n = ($urandom_range(0, 12) == 0);
            f = ($urandom_range(0, 59) == 0);
            step(g, n, f);
            if (g || n || f)
                $display("txn %0d go=%0d next=%0d fail=%0d -> level=%0d play=%0d won=%0d lost=%0d", t, g, n, f, curr_level, playing, won, lost);
            total++;
            if (curr_level !== 4'(m_level) || speed_count !== 8'(exp_speed(m_level)) || num_blocks !== 3'(exp_blocks(m_level))) begin
                bad++; $display("FAIL rand_level t=%0d: got lvl=%0d spd=%0d blk=%0d want %0d %0d %0d", t, curr_level, speed_count, num_blocks, m_level, exp_speed(m_level), exp_blocks(m_level));
            end
            total++;
            if ({playing, won, lost} !== {m_mode == 1, m_mode == 2, m_mode == 3}) begin
                bad++; $display("FAIL rand_state t=%0d: got %b want %b", t, {playing, won, lost}, {m_mode == 1, m_mode == 2, m_mode == 3});
            end
            total++;
            if (tick !== exp_tick()) begin
                bad++; $display("FAIL rand_tick t=%0d: got %b want %b", t, tick, exp_tick());
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        go = 1'b0; next_signal = 1'b0; fail = 1'b0;
        model_reset();
        test_reset();
        test_first_ticks();
        test_levels();
        test_fail_priority();
        test_ignored_inputs();
        test_next_midperiod();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
